// File: rtl/rv0_bru_if.sv
// Issue-side bundle for the branch resolution unit: input handshake, operands,
// prediction, result handshake, flush and statistics counters.
interface rv0_bru_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             bru_in_valid_i;
  logic             bru_in_ready_o;
  logic [31:0]      bru_insn_i;
  logic [XLEN-1:0]  bru_addr_i;
  logic [XLEN-1:0]  bru_rdata1_i;
  logic [XLEN-1:0]  bru_rdata2_i;
  logic             bru_pred_taken_i;
  logic [XLEN-1:0]  bru_pred_target_i;
  logic             bru_kill_i;
  logic             bru_res_valid_o;
  logic             bru_res_ready_i;
  logic [XLEN-1:0]  bru_res_wdata_o;
  logic [XLEN-1:0]  bru_res_target_o;
  logic             bru_res_taken_o;
  logic             bru_res_mispred_o;
  logic             bru_res_misalign_o;
  logic             bru_res_illegal_o;
  logic             bru_cnt_clr_i;
  logic [CNT_W-1:0] bru_cnt_ct_o;
  logic [CNT_W-1:0] bru_cnt_mispred_o;

  // The branch unit itself
  modport slave (
    input  bru_in_valid_i, bru_insn_i, bru_addr_i, bru_rdata1_i, bru_rdata2_i,
    input  bru_pred_taken_i, bru_pred_target_i, bru_kill_i, bru_res_ready_i, bru_cnt_clr_i,
    output bru_in_ready_o, bru_res_valid_o, bru_res_wdata_o, bru_res_target_o,
    output bru_res_taken_o, bru_res_mispred_o, bru_res_misalign_o, bru_res_illegal_o,
    output bru_cnt_ct_o, bru_cnt_mispred_o
  );

  // Issue / writeback side
  modport master (
    output bru_in_valid_i, bru_insn_i, bru_addr_i, bru_rdata1_i, bru_rdata2_i,
    output bru_pred_taken_i, bru_pred_target_i, bru_kill_i, bru_res_ready_i, bru_cnt_clr_i,
    input  bru_in_ready_o, bru_res_valid_o, bru_res_wdata_o, bru_res_target_o,
    input  bru_res_taken_o, bru_res_mispred_o, bru_res_misalign_o, bru_res_illegal_o,
    input  bru_cnt_ct_o, bru_cnt_mispred_o
  );
endinterface

// File: rtl/rv0_bru.sv
// Pipelined branch resolution unit: resolves JAL/JALR/BRANCH, checks against the
// fetch prediction, registers the result one cycle later and keeps saturating stats.
module rv0_bru #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  rv0_bru_if.slave   bru
);
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_j, imm_i, imm_b, pc_plus4;
  logic            op_eq, op_lt, op_ltu;

  assign opcode   = bru.bru_insn_i[6:0];
  assign funct3   = bru.bru_insn_i[14:12];
  assign imm_j    = {{(XLEN-21){bru.bru_insn_i[31]}}, bru.bru_insn_i[31], bru.bru_insn_i[19:12],
                     bru.bru_insn_i[20], bru.bru_insn_i[30:21], 1'b0};
  assign imm_i    = {{(XLEN-12){bru.bru_insn_i[31]}}, bru.bru_insn_i[31:20]};
  assign imm_b    = {{(XLEN-13){bru.bru_insn_i[31]}}, bru.bru_insn_i[31], bru.bru_insn_i[7],
                     bru.bru_insn_i[30:25], bru.bru_insn_i[11:8], 1'b0};
  assign pc_plus4 = bru.bru_addr_i + XLEN'(4);
  assign op_eq    = bru.bru_rdata1_i == bru.bru_rdata2_i;
  assign op_lt    = $signed(bru.bru_rdata1_i) < $signed(bru.bru_rdata2_i);
  assign op_ltu   = bru.bru_rdata1_i < bru.bru_rdata2_i;

  logic            is_ct, illegal, taken, misalign, mispred;
  logic [XLEN-1:0] ct_tgt, link;

  // Decode and resolve taken / target-if-taken / link value
  always_comb begin
    is_ct   = 1'b0;
    illegal = 1'b0;
    taken   = 1'b0;
    ct_tgt  = pc_plus4;
    link    = '0;
    case (opcode)
      OpJal: begin
        is_ct  = 1'b1;
        taken  = 1'b1;
        ct_tgt = bru.bru_addr_i + imm_j;
        link   = pc_plus4;
      end
      OpJalr: begin
        is_ct = 1'b1;
        if (funct3 != 3'b000) begin
          illegal = 1'b1;
        end else begin
          taken  = 1'b1;
          ct_tgt = (bru.bru_rdata1_i + imm_i) & ~XLEN'(1);
          link   = pc_plus4;
        end
      end
      OpBranch: begin
        is_ct  = 1'b1;
        ct_tgt = bru.bru_addr_i + imm_b;
        case (funct3)
          3'b000:  taken = op_eq;
          3'b001:  taken = !op_eq;
          3'b100:  taken = op_lt;
          3'b101:  taken = !op_lt;
          3'b110:  taken = op_ltu;
          3'b111:  taken = !op_ltu;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // The misalign exception owns the redirect, so it suppresses mispred
  assign misalign = taken && ((IALIGN == 32'd16) ? ct_tgt[0] : (ct_tgt[1:0] != 2'b00));
  assign mispred  = !illegal && !misalign &&
                    ((taken != bru.bru_pred_taken_i) ||
                     (taken && (ct_tgt != bru.bru_pred_target_i)));

  logic            valid_q, valid_d, in_ready, accept, fire;
  logic            taken_q, mispred_q, misalign_q, illegal_q, ct_q;
  logic [XLEN-1:0] wdata_q, target_q;
  logic [CNT_W-1:0] cnt_ct_q, cnt_mp_q;

  assign in_ready = !valid_q || bru.bru_res_ready_i;
  assign accept   = bru.bru_in_valid_i && in_ready;
  assign fire     = valid_q && bru.bru_res_ready_i && !bru.bru_kill_i;

  // Result-valid next state: kill wins, then a new accept, then retire on handshake
  always_comb begin
    valid_d = valid_q;
    if (bru.bru_kill_i)               valid_d = 1'b0;
    else if (accept)                  valid_d = 1'b1;
    else if (bru.bru_res_ready_i)     valid_d = 1'b0;
  end

  // Result register: loads on an unkilled accept, otherwise holds
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      wdata_q    <= '0;
      target_q   <= '0;
      taken_q    <= 1'b0;
      mispred_q  <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      ct_q       <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept && !bru.bru_kill_i) begin
        wdata_q    <= link;
        target_q   <= taken ? ct_tgt : pc_plus4;
        taken_q    <= taken;
        mispred_q  <= mispred;
        misalign_q <= misalign;
        illegal_q  <= illegal;
        ct_q       <= is_ct && !illegal;
      end
    end
  end

  // Saturating statistics counters, clear has priority over increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_ct_q <= '0;
      cnt_mp_q <= '0;
    end else if (bru.bru_cnt_clr_i) begin
      cnt_ct_q <= '0;
      cnt_mp_q <= '0;
    end else if (fire) begin
      if (ct_q && (cnt_ct_q != '1))      cnt_ct_q <= cnt_ct_q + CNT_W'(1);
      if (mispred_q && (cnt_mp_q != '1)) cnt_mp_q <= cnt_mp_q + CNT_W'(1);
    end
  end

  assign bru.bru_in_ready_o     = in_ready;
  assign bru.bru_res_valid_o    = valid_q;
  assign bru.bru_res_wdata_o    = wdata_q;
  assign bru.bru_res_target_o   = target_q;
  assign bru.bru_res_taken_o    = taken_q;
  assign bru.bru_res_mispred_o  = mispred_q;
  assign bru.bru_res_misalign_o = misalign_q;
  assign bru.bru_res_illegal_o  = illegal_q;
  assign bru.bru_cnt_ct_o       = cnt_ct_q;
  assign bru.bru_cnt_mispred_o  = cnt_mp_q;
endmodule

// File: tb/tb_rv0_bru.sv
// Bench for rv0_bru: three instances share one stimulus stream
// (a: IALIGN=32/CNT_W=32, b: IALIGN=16, c: CNT_W=4 for saturation).
module tb_rv0_bru;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, pred_taken = 1'b0, kill = 1'b0, res_ready = 1'b1, cnt_clr = 1'b0;
  logic [31:0] insn = '0, addr = '0, rs1 = '0, rs2 = '0, pred_target = '0;
  int          n_vec = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rv0_bru_if #(.XLEN(32), .CNT_W(32)) if_a ();
  rv0_bru_if #(.XLEN(32), .CNT_W(32)) if_b ();
  rv0_bru_if #(.XLEN(32), .CNT_W(4))  if_c ();

`define TB_DRIVE(IF) \
  assign IF.bru_in_valid_i = in_valid; assign IF.bru_insn_i = insn; \
  assign IF.bru_addr_i = addr; assign IF.bru_rdata1_i = rs1; assign IF.bru_rdata2_i = rs2; \
  assign IF.bru_pred_taken_i = pred_taken; assign IF.bru_pred_target_i = pred_target; \
  assign IF.bru_kill_i = kill; assign IF.bru_res_ready_i = res_ready; \
  assign IF.bru_cnt_clr_i = cnt_clr;
  `TB_DRIVE(if_a)
  `TB_DRIVE(if_b)
  `TB_DRIVE(if_c)
`undef TB_DRIVE

  rv0_bru #(.XLEN(32), .IALIGN(32), .CNT_W(32)) u_a (.clk_i(clk), .rst_i(rst), .bru(if_a.slave));
  rv0_bru #(.XLEN(32), .IALIGN(16), .CNT_W(32)) u_b (.clk_i(clk), .rst_i(rst), .bru(if_b.slave));
  rv0_bru #(.XLEN(32), .IALIGN(32), .CNT_W(4))  u_c (.clk_i(clk), .rst_i(rst), .bru(if_c.slave));

  typedef struct {
    logic [31:0] insn, addr, rs1, rs2;
    logic        pt;
    logic [31:0] ptgt, wdata, target;
    logic        taken, mispred, mis32, mis16, illegal, ct;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] enc_jal(input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd1, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [12:0] off);
    return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    in_valid    = 1'b1;
    insn        = v.insn;
    addr        = v.addr;
    rs1         = v.rs1;
    rs2         = v.rs2;
    pred_taken  = v.pt;
    pred_target = v.ptgt;
  endtask

  initial begin
    int exp_ct, exp_mp;
    vec_t bne_mp;
    // insn, addr, rs1, rs2, pt, ptgt, wdata, target, taken, mispred, mis32, mis16, ill, ct
    vecs[0]  = '{enc_jal(21'h20), 32'h1000, 32'h0, 32'h0, 1'b1, 32'h1020,
                 32'h1004, 32'h1020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{enc_br(3'b100, 13'h1FF8), 32'h2000, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0,
                 32'h0, 32'h1FF8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{enc_br(3'b110, 13'h1FF8), 32'h2000, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0,
                 32'h0, 32'h2004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{enc_jalr(3'b000, 12'h002), 32'h3100, 32'h3001, 32'h0, 1'b1, 32'h3002,
                 32'h3104, 32'h3002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{enc_br(3'b000, 13'h0010), 32'h400, 32'h5, 32'h5, 1'b1, 32'h410,
                 32'h0, 32'h410, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{enc_br(3'b001, 13'h0040), 32'h500, 32'h5, 32'h5, 1'b1, 32'h540,
                 32'h0, 32'h504, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{enc_br(3'b101, 13'h0020), 32'h600, 32'h80000000, 32'h0, 1'b0, 32'h0,
                 32'h0, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{enc_br(3'b111, 13'h1F00), 32'h700, 32'h80000000, 32'h0, 1'b1, 32'h700,
                 32'h0, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{enc_br(3'b010, 13'h0010), 32'h800, 32'h0, 32'h0, 1'b1, 32'h810,
                 32'h0, 32'h804, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{enc_jalr(3'b001, 12'h004), 32'h900, 32'h100, 32'h0, 1'b1, 32'h104,
                 32'h0, 32'h904, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h00000013, 32'hA00, 32'h0, 32'h0, 1'b1, 32'hA40,
                 32'h0, 32'hA04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{enc_jal(21'h6), 32'h1000, 32'h0, 32'h0, 1'b1, 32'h1006,
                 32'h1004, 32'h1006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{enc_jal(21'h20), 32'hFFFFFFF0, 32'h0, 32'h0, 1'b0, 32'h0,
                 32'hFFFFFFF4, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{enc_br(3'b100, 13'h0008), 32'hB00, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0,
                 32'h0, 32'hB04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(if_a.bru_res_valid_o), 64'd0);
    chk("rst_in_ready", 64'(if_a.bru_in_ready_o), 64'd1);
    chk("rst_target", 64'(if_a.bru_res_target_o), 64'd0);
    chk("rst_wdata", 64'(if_a.bru_res_wdata_o), 64'd0);
    chk("rst_flags", 64'({if_a.bru_res_taken_o, if_a.bru_res_mispred_o,
                          if_a.bru_res_misalign_o, if_a.bru_res_illegal_o}), 64'd0);
    chk("rst_cnt_ct", 64'(if_a.bru_cnt_ct_o), 64'd0);
    chk("rst_cnt_mp", 64'(if_a.bru_cnt_mispred_o), 64'd0);
    rst = 1'b0;

    // Table: one vector per cycle, result checked one cycle after acceptance
    exp_ct = 0;
    exp_mp = 0;
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      step();
      chk($sformatf("v%0d_valid", i), 64'(if_a.bru_res_valid_o), 64'd1);
      chk($sformatf("v%0d_wdata", i), 64'(if_a.bru_res_wdata_o), 64'(vecs[i].wdata));
      chk($sformatf("v%0d_target", i), 64'(if_a.bru_res_target_o), 64'(vecs[i].target));
      chk($sformatf("v%0d_taken", i), 64'(if_a.bru_res_taken_o), 64'(vecs[i].taken));
      chk($sformatf("v%0d_mispred", i), 64'(if_a.bru_res_mispred_o), 64'(vecs[i].mispred));
      chk($sformatf("v%0d_mis32", i), 64'(if_a.bru_res_misalign_o), 64'(vecs[i].mis32));
      chk($sformatf("v%0d_mis16", i), 64'(if_b.bru_res_misalign_o), 64'(vecs[i].mis16));
      chk($sformatf("v%0d_illegal", i), 64'(if_a.bru_res_illegal_o), 64'(vecs[i].illegal));
      exp_ct += int'(vecs[i].ct);
      exp_mp += int'(vecs[i].mispred);
    end
    in_valid = 1'b0;
    step();
    chk("tbl_cnt_ct", 64'(if_a.bru_cnt_ct_o), 64'(exp_ct));
    chk("tbl_cnt_mp", 64'(if_a.bru_cnt_mispred_o), 64'(exp_mp));

    // Saturation: 17 more mispredicted branches (BNE equal, predicted taken)
    bne_mp = vecs[5];
    for (int i = 0; i < 17; i++) begin
      apply(bne_mp);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_c_ct", 64'(if_c.bru_cnt_ct_o), 64'hF);
    chk("sat_c_mp", 64'(if_c.bru_cnt_mispred_o), 64'hF);
    chk("sat_a_ct", 64'(if_a.bru_cnt_ct_o), 64'(exp_ct + 17));
    chk("sat_a_mp", 64'(if_a.bru_cnt_mispred_o), 64'(exp_mp + 17));

    // Clear together with a retiring result
    apply(vecs[1]);
    step();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_a_ct", 64'(if_a.bru_cnt_ct_o), 64'd0);
    chk("clr_a_mp", 64'(if_a.bru_cnt_mispred_o), 64'd0);
    chk("clr_c_ct", 64'(if_c.bru_cnt_ct_o), 64'd0);

    // Back-pressure: X held while consumer stalls, Y waits at the input
    res_ready = 1'b0;
    apply(vecs[0]);
    step();
    apply(vecs[4]);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_in_ready", i), 64'(if_a.bru_in_ready_o), 64'd0);
      step();
      chk($sformatf("bp%0d_valid", i), 64'(if_a.bru_res_valid_o), 64'd1);
      chk($sformatf("bp%0d_target", i), 64'(if_a.bru_res_target_o), 64'h1020);
      chk($sformatf("bp%0d_wdata", i), 64'(if_a.bru_res_wdata_o), 64'h1004);
      chk($sformatf("bp%0d_cnt", i), 64'(if_a.bru_cnt_ct_o), 64'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(if_a.bru_in_ready_o), 64'd1);
    step();
    chk("bp_y_target", 64'(if_a.bru_res_target_o), 64'h410);
    chk("bp_y_valid", 64'(if_a.bru_res_valid_o), 64'd1);
    chk("bp_x_counted", 64'(if_a.bru_cnt_ct_o), 64'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", 64'(if_a.bru_res_valid_o), 64'd0);
    chk("bp_y_counted", 64'(if_a.bru_cnt_ct_o), 64'd2);
    chk("bp_mp", 64'(if_a.bru_cnt_mispred_o), 64'd0);

    // Kill with a result pending and a new input accepted in the same cycle
    apply(vecs[1]);
    step();
    apply(vecs[0]);
    kill = 1'b1;
    step();
    kill = 1'b0;
    in_valid = 1'b0;
    chk("kill_valid", 64'(if_a.bru_res_valid_o), 64'd0);
    chk("kill_cnt_ct", 64'(if_a.bru_cnt_ct_o), 64'd2);
    chk("kill_cnt_mp", 64'(if_a.bru_cnt_mispred_o), 64'd0);
    step();
    chk("kill_discard", 64'(if_a.bru_res_valid_o), 64'd0);
    chk("kill_cnt_ct2", 64'(if_a.bru_cnt_ct_o), 64'd2);

    // Asynchronous reset while a result is stalled
    res_ready = 1'b0;
    apply(vecs[0]);
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(if_a.bru_res_valid_o), 64'd0);
    chk("arst_cnt_ct", 64'(if_a.bru_cnt_ct_o), 64'd0);
    chk("arst_in_ready", 64'(if_a.bru_in_ready_o), 64'd1);
    chk("arst_target", 64'(if_a.bru_res_target_o), 64'd0);
    step();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
